// File: rtl/md_sched.sv
// Multiply/divide sequencer for the E stage: owns HI/LO, runs a fixed-latency
// busy countdown per op, stalls MD-class instructions while busy.
`timescale 1ns/1ps
module md_sched #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  op_E,
    input  logic [31:0] rs_E,
    input  logic [31:0] rt_E,
    input  logic        exc_flush,
    output logic        stall_E,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mdOut_E
);

    localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_n_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_n_s;
    logic [31:0]        a_r;
    logic [31:0]        a_n_s;
    logic [31:0]        b_r;
    logic [31:0]        b_n_s;
    logic [3:0]         op_r;
    logic [3:0]         op_n_s;
    logic [31:0]        hi_r;
    logic [31:0]        hi_n_s;
    logic [31:0]        lo_r;
    logic [31:0]        lo_n_s;

    logic               md_op_s;
    logic               busy_s;
    logic [63:0]        prod_signed_s;
    logic [63:0]        prod_unsigned_s;
    logic               div_signed_s;
    logic               a_neg_s;
    logic               b_neg_s;
    logic [31:0]        a_mag_s;
    logic [31:0]        b_mag_s;
    logic [31:0]        b_safe_s;
    logic [31:0]        q_mag_s;
    logic [31:0]        r_mag_s;
    logic [31:0]        quot_s;
    logic [31:0]        rem_s;

    assign md_op_s = (op_E >= OP_MULT) && (op_E <= OP_MFLO);
    assign busy_s  = (state_r == BUSY);

    // Low 64 bits of the product of sign-extended operands equal the signed product
    assign prod_signed_s   = {{32{a_r[31]}}, a_r} * {{32{b_r[31]}}, b_r};
    assign prod_unsigned_s = {32'd0, a_r} * {32'd0, b_r};

    // Signed divide via magnitudes: quotient truncates toward zero, remainder takes dividend sign
    assign div_signed_s = (op_r == OP_DIV);
    assign a_neg_s      = div_signed_s & a_r[31];
    assign b_neg_s      = div_signed_s & b_r[31];
    assign a_mag_s      = a_neg_s ? (32'd0 - a_r) : a_r;
    assign b_mag_s      = b_neg_s ? (32'd0 - b_r) : b_r;
    assign b_safe_s     = (b_mag_s == 32'd0) ? 32'd1 : b_mag_s;
    assign q_mag_s      = a_mag_s / b_safe_s;
    assign r_mag_s      = a_mag_s % b_safe_s;
    assign quot_s       = (a_neg_s ^ b_neg_s) ? (32'd0 - q_mag_s) : q_mag_s;
    assign rem_s        = a_neg_s ? (32'd0 - r_mag_s) : r_mag_s;

    // Next-state, operand latch and HI/LO update logic
    always_comb begin
        state_n_s = state_r;
        cnt_n_s   = cnt_r;
        a_n_s     = a_r;
        b_n_s     = b_r;
        op_n_s    = op_r;
        hi_n_s    = hi_r;
        lo_n_s    = lo_r;
        case (state_r)
            IDLE: begin
                if (!exc_flush) begin
                    case (op_E)
                        OP_MULT, OP_MULTU: begin
                            a_n_s     = rs_E;
                            b_n_s     = rt_E;
                            op_n_s    = op_E;
                            cnt_n_s   = CNT_W'(MULT_CYC);
                            state_n_s = BUSY;
                        end
                        OP_DIV, OP_DIVU: begin
                            a_n_s     = rs_E;
                            b_n_s     = rt_E;
                            op_n_s    = op_E;
                            cnt_n_s   = CNT_W'(DIV_CYC);
                            state_n_s = BUSY;
                        end
                        OP_MTHI: hi_n_s = rs_E;
                        OP_MTLO: lo_n_s = rs_E;
                        default: state_n_s = IDLE;
                    endcase
                end else begin
                    state_n_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r <= CNT_W'(1)) begin
                    cnt_n_s   = {CNT_W{1'b0}};
                    state_n_s = IDLE;
                    case (op_r)
                        OP_MULT:  {hi_n_s, lo_n_s} = prod_signed_s;
                        OP_MULTU: {hi_n_s, lo_n_s} = prod_unsigned_s;
                        OP_DIV, OP_DIVU: begin
                            // A zero divisor leaves HI/LO untouched
                            if (b_r != 32'd0) begin
                                hi_n_s = rem_s;
                                lo_n_s = quot_s;
                            end else begin
                                hi_n_s = hi_r;
                                lo_n_s = lo_r;
                            end
                        end
                        default: begin
                            hi_n_s = hi_r;
                            lo_n_s = lo_r;
                        end
                    endcase
                end else begin
                    cnt_n_s = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                state_n_s = IDLE;
                cnt_n_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, counter, operand latches and HI/LO registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            op_r    <= 4'd0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
        end else begin
            state_r <= state_n_s;
            cnt_r   <= cnt_n_s;
            a_r     <= a_n_s;
            b_r     <= b_n_s;
            op_r    <= op_n_s;
            hi_r    <= hi_n_s;
            lo_r    <= lo_n_s;
        end
    end

    // mfhi/mflo read path into the E/M pipeline register
    always_comb begin
        mdOut_E = 32'd0;
        case (op_E)
            OP_MFHI: mdOut_E = hi_r;
            OP_MFLO: mdOut_E = lo_r;
            default: mdOut_E = 32'd0;
        endcase
    end

    assign busy    = busy_s;
    assign stall_E = md_op_s & busy_s;
    assign hi      = hi_r;
    assign lo      = lo_r;

endmodule

// File: tb/tb_md_sched.sv
// Directed self-checking bench for md_sched (MULT_CYC=5, DIV_CYC=10).
`timescale 1ns/1ps
module tb_md_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  op_E;
    logic [31:0] rs_E;
    logic [31:0] rt_E;
    logic        exc_flush;
    logic        stall_E;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mdOut_E;

    int checks   = 0;
    int failures = 0;

    md_sched #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .op_E      (op_E),
        .rs_E      (rs_E),
        .rt_E      (rt_E),
        .exc_flush (exc_flush),
        .stall_E   (stall_E),
        .busy      (busy),
        .hi        (hi),
        .lo        (lo),
        .mdOut_E   (mdOut_E)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        op_E = op;
        rs_E = a;
        rt_E = b;
    endtask

    // Counts consecutive sampled cycles with busy high, bounded at 40
    task automatic busy_len(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(posedge clk);
            #3;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        exc_flush = 1'b0;
        drive(4'd0, 32'd0, 32'd0);
        #12;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (stall_E !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_E); end
        checks++; if (hi !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
        reset = 1'b1;
        drive(4'd7, 32'd0, 32'd0);
        #1;
        checks++; if (mdOut_E !== 32'd0) begin failures++; $display("FAIL reset_mdout got=%h exp=0", mdOut_E); end
    endtask

    task automatic test_mult();
        int n;
        drive(4'd1, 32'hFFFFFFFE, 32'd3);
        #1;
        checks++; if (stall_E !== 1'b0) begin failures++; $display("FAIL mult_idle_stall got=%b exp=0", stall_E); end
        cyc();
        drive(4'd0, 32'd0, 32'd0);
        #1;
        checks++; if (stall_E !== 1'b0) begin failures++; $display("FAIL mult_nonmd_stall got=%b exp=0", stall_E); end
        busy_len(n);
        checks++; if (n !== 5) begin failures++; $display("FAIL mult_busy_len got=%0d exp=5", n); end
        checks++; if (hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
        checks++; if (lo !== 32'hFFFFFFFA) begin failures++; $display("FAIL mult_lo got=%h exp=fffffffa", lo); end
    endtask

    task automatic test_multu_mfhi();
        int n;
        drive(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        cyc();
        drive(4'd7, 32'd0, 32'd0);
        #1;
        n = 0;
        while (stall_E === 1'b1 && n < 40) begin
            n++;
            @(posedge clk);
            #3;
        end
        checks++; if (n !== 5) begin failures++; $display("FAIL multu_stall_len got=%0d exp=5", n); end
        checks++; if (mdOut_E !== 32'hFFFFFFFE) begin failures++; $display("FAIL multu_mfhi got=%h exp=fffffffe", mdOut_E); end
        checks++; if (lo !== 32'h00000001) begin failures++; $display("FAIL multu_lo got=%h exp=00000001", lo); end
        drive(4'd0, 32'd0, 32'd0);
    endtask

    task automatic test_div();
        int n;
        drive(4'd3, 32'hFFFFFFF9, 32'd2);
        cyc();
        drive(4'd0, 32'd0, 32'd0);
        #1;
        busy_len(n);
        checks++; if (n !== 10) begin failures++; $display("FAIL div_busy_len got=%0d exp=10", n); end
        checks++; if (lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_lo got=%h exp=fffffffd", lo); end
        checks++; if (hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_hi got=%h exp=ffffffff", hi); end
        drive(4'd4, 32'd7, 32'd0);
        cyc();
        drive(4'd0, 32'd0, 32'd0);
        #1;
        busy_len(n);
        checks++; if (n !== 10) begin failures++; $display("FAIL divz_busy_len got=%0d exp=10", n); end
        checks++; if (hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL divz_hi got=%h exp=ffffffff", hi); end
        checks++; if (lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL divz_lo got=%h exp=fffffffd", lo); end
        drive(4'd3, 32'h80000000, 32'hFFFFFFFF);
        cyc();
        drive(4'd0, 32'd0, 32'd0);
        #1;
        busy_len(n);
        checks++; if (lo !== 32'h80000000) begin failures++; $display("FAIL divovf_lo got=%h exp=80000000", lo); end
        checks++; if (hi !== 32'h00000000) begin failures++; $display("FAIL divovf_hi got=%h exp=00000000", hi); end
        drive(4'd4, 32'd100, 32'd7);
        cyc();
        drive(4'd0, 32'd0, 32'd0);
        #1;
        busy_len(n);
        checks++; if (lo !== 32'd14) begin failures++; $display("FAIL divu_lo got=%h exp=0000000e", lo); end
        checks++; if (hi !== 32'd2) begin failures++; $display("FAIL divu_hi got=%h exp=00000002", hi); end
    endtask

    task automatic test_flush_start();
        drive(4'd3, 32'd100, 32'd7);
        exc_flush = 1'b1;
        cyc();
        exc_flush = 1'b0;
        drive(4'd0, 32'd0, 32'd0);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_start_busy got=%b exp=0", busy); end
        checks++; if (hi !== 32'd2) begin failures++; $display("FAIL flush_start_hi got=%h exp=00000002", hi); end
        checks++; if (lo !== 32'd14) begin failures++; $display("FAIL flush_start_lo got=%h exp=0000000e", lo); end
        drive(4'd5, 32'hDEADBEEF, 32'd0);
        exc_flush = 1'b1;
        cyc();
        exc_flush = 1'b0;
        drive(4'd0, 32'd0, 32'd0);
        #1;
        checks++; if (hi !== 32'd2) begin failures++; $display("FAIL flush_mthi_hi got=%h exp=00000002", hi); end
    endtask

    task automatic test_flush_busy();
        int n;
        drive(4'd1, 32'd7, 32'd6);
        cyc();
        drive(4'd0, 32'd0, 32'd0);
        cyc();
        exc_flush = 1'b1;
        cyc();
        exc_flush = 1'b0;
        #1;
        busy_len(n);
        checks++; if (n !== 3) begin failures++; $display("FAIL flush_busy_remaining got=%0d exp=3", n); end
        checks++; if (lo !== 32'd42) begin failures++; $display("FAIL flush_busy_lo got=%h exp=0000002a", lo); end
        checks++; if (hi !== 32'd0) begin failures++; $display("FAIL flush_busy_hi got=%h exp=00000000", hi); end
    endtask

    task automatic test_mt_mf();
        drive(4'd5, 32'h12345678, 32'd0);
        cyc();
        drive(4'd7, 32'd0, 32'd0);
        #1;
        checks++; if (mdOut_E !== 32'h12345678) begin failures++; $display("FAIL mthi_mfhi got=%h exp=12345678", mdOut_E); end
        checks++; if (stall_E !== 1'b0) begin failures++; $display("FAIL mfhi_stall got=%b exp=0", stall_E); end
        drive(4'd6, 32'hCAFEF00D, 32'd0);
        cyc();
        drive(4'd8, 32'd0, 32'd0);
        #1;
        checks++; if (mdOut_E !== 32'hCAFEF00D) begin failures++; $display("FAIL mtlo_mflo got=%h exp=cafef00d", mdOut_E); end
        drive(4'd9, 32'd0, 32'd0);
        #1;
        checks++; if (mdOut_E !== 32'd0) begin failures++; $display("FAIL op9_mdout got=%h exp=0", mdOut_E); end
        checks++; if (hi !== 32'h12345678) begin failures++; $display("FAIL mtlo_keeps_hi got=%h exp=12345678", hi); end
        drive(4'd0, 32'd0, 32'd0);
    endtask

    task automatic test_back_to_back();
        int n;
        drive(4'd1, 32'd3, 32'd4);
        cyc();
        drive(4'd1, 32'd5, 32'd6);
        #1;
        n = 0;
        while (stall_E === 1'b1 && n < 40) begin
            n++;
            @(posedge clk);
            #3;
        end
        checks++; if (n !== 5) begin failures++; $display("FAIL b2b_stall_len got=%0d exp=5", n); end
        checks++; if (lo !== 32'd12) begin failures++; $display("FAIL b2b_first_lo got=%h exp=0000000c", lo); end
        cyc();
        drive(4'd0, 32'd0, 32'd0);
        #1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_second_start got=%b exp=1", busy); end
        busy_len(n);
        checks++; if (n !== 5) begin failures++; $display("FAIL b2b_second_len got=%0d exp=5", n); end
        checks++; if (lo !== 32'd30) begin failures++; $display("FAIL b2b_second_lo got=%h exp=0000001e", lo); end
        checks++; if (hi !== 32'd0) begin failures++; $display("FAIL b2b_second_hi got=%h exp=00000000", hi); end
    endtask

    task automatic test_reset_mid();
        drive(4'd5, 32'hA5A5A5A5, 32'd0);
        cyc();
        drive(4'd1, 32'd2, 32'd3);
        cyc();
        drive(4'd0, 32'd0, 32'd0);
        cyc();
        cyc();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rstmid_pre_busy got=%b exp=1", busy); end
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        checks++; if (hi !== 32'd0) begin failures++; $display("FAIL rstmid_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'd0) begin failures++; $display("FAIL rstmid_lo got=%h exp=0", lo); end
        cyc();
        reset = 1'b1;
        cyc();
        cyc();
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_after_busy got=%b exp=0", busy); end
        checks++; if (lo !== 32'd0) begin failures++; $display("FAIL rstmid_no_commit got=%h exp=0", lo); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu_mfhi();
        test_div();
        test_flush_start();
        test_flush_busy();
        test_mt_mf();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
